// File: rtl/display_scan_controller_pkg.sv
// display_pkg: shared flag codes, scan FSM state type and default digit count for the display scan controller
package display_pkg;
   localparam logic [2:0] FLAG_DP    = 3'd0;
   localparam logic [2:0] FLAG_PLAIN = 3'd1;
   localparam logic [2:0] FLAG_NEG   = 3'd2;
   localparam int NUM_DIGITS_DEF = 4;
   typedef enum logic {BLANK, SHOW} scan_state_e;
endpackage

// File: rtl/display_scan_controller_prescaler.sv
// scan_prescaler: per-slot cycle counter; slot_end_o on the wrap cycle, blank_end_o on the last blanking cycle
//   clk, reset (async, active-high) | slot_end_o, blank_end_o
module scan_prescaler #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   output logic slot_end_o,
   output logic blank_end_o
);
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   assign slot_end_o  = cnt_q == CW'(REFRESH_DIV - 1);
   assign blank_end_o = cnt_q == CW'(BLANK_CYCLES - 1);
   assign cnt_d       = slot_end_o ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: double-buffered time-multiplexed scan of a common-anode seven-segment display
//   clk, reset (async, active-high)
//   load_valid/load_ready/value_in/flag_in: value handshake into the pending buffer
//   digit_out/idx_out/flag_out: registered decoder inputs for the current slot
//   an: active-low anodes; frame_done: pulse at the end of the last slot
//   Option LEADING_ZERO_BLANK_EN: keep anodes of leading-zero slots dark
module display_scan_controller
   import display_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 16,
   parameter int NUM_DIGITS   = NUM_DIGITS_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [2:0]              flag_in,
   output logic [3:0]              digit_out,
   output logic [2:0]              idx_out,
   output logic [2:0]              flag_out,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);
   localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);
   scan_state_e state_q, state_d;
   logic slot_end, blank_end, frame_end, commit, accept;
   logic [2:0] idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] pend_q, pend_d, act_q, act_d;
   logic [2:0] pend_flag_q, pend_flag_d, act_flag_q, act_flag_d, flag_q, flag_d;
   logic pend_full_q, pend_full_d;
   logic [3:0] digit_q, digit_d;
   logic [NUM_DIGITS-1:0] hide, onehot;
   scan_prescaler #(.REFRESH_DIV(REFRESH_DIV), .BLANK_CYCLES(BLANK_CYCLES)) u_pre (
      .clk(clk), .reset(reset), .slot_end_o(slot_end), .blank_end_o(blank_end)
   );
   assign frame_end   = slot_end && idx_q == LAST;
   assign commit      = frame_end && pend_full_q;
   assign accept      = load_valid && !pend_full_q;
   assign idx_d       = slot_end ? (idx_q == LAST ? 3'd0 : idx_q + 3'd1) : idx_q;
   assign pend_d      = accept ? value_in : pend_q;
   assign pend_flag_d = accept ? flag_in : pend_flag_q;
   assign pend_full_d = accept || (pend_full_q && !commit);
   assign act_d       = commit ? pend_q : act_q;
   assign act_flag_d  = commit ? pend_flag_q : act_flag_q;
   // act_d already holds the new frame on a commit, so slot 0 never shows stale digits
   assign digit_d     = slot_end ? act_d[4*idx_d +: 4] : digit_q;
   assign flag_d      = slot_end ? act_flag_d : flag_q;
   assign onehot      = NUM_DIGITS'(1) << idx_q;
`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      logic zr;
      hide = '0;
      zr = 1'b1;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         zr = zr && act_q[4*k +: 4] == 4'd0;
         hide[k] = zr && !(k == 3 && act_flag_q == FLAG_NEG);
      end
   end
`else
   assign hide = '0;
`endif
   always_comb begin
      state_d = state_q;
      an = '1;
      if (slot_end) state_d = BLANK;
      else if (blank_end) state_d = SHOW;
      if (state_q == SHOW && !(|(hide & onehot))) an = ~onehot;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q     <= BLANK;
         idx_q       <= '0;
         pend_q      <= '0;
         pend_flag_q <= FLAG_PLAIN;
         pend_full_q <= 1'b0;
         act_q       <= '0;
         act_flag_q  <= FLAG_PLAIN;
         digit_q     <= '0;
         flag_q      <= FLAG_PLAIN;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pend_q      <= pend_d;
         pend_flag_q <= pend_flag_d;
         pend_full_q <= pend_full_d;
         act_q       <= act_d;
         act_flag_q  <= act_flag_d;
         digit_q     <= digit_d;
         flag_q      <= flag_d;
      end
   assign load_ready = !pend_full_q;
   assign digit_out  = digit_q;
   assign idx_out    = idx_q;
   assign flag_out   = flag_q;
   assign frame_done = frame_end;
endmodule
